// File: rtl/full_half_sub.sv
// Registered WIDTH-bit ripple-borrow subtractor built from half-subtractor cells.
// Computes a - b - c; difference and borrow-out are captured when in_valid is high.

module half_sub (
  input  logic x_i,
  input  logic y_i,
  output logic d_o,
  output logic bo_o
);
  assign d_o  = x_i ^ y_i;
  assign bo_o = ~x_i & y_i;
endmodule

module full_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);
  logic d1;
  logic b1;
  logic b2;

  half_sub u_hs1 (
    .x_i  (a_i),
    .y_i  (b_i),
    .d_o  (d1),
    .bo_o (b1)
  );

  half_sub u_hs2 (
    .x_i  (d1),
    .y_i  (bin_i),
    .d_o  (diff_o),
    .bo_o (b2)
  );

  assign bout_o = b1 | b2;
endmodule

module full_half_sub #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             out_valid
);
  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] diff_d;
  logic             borr_d;
  logic [WIDTH-1:0] diff_q;
  logic             borr_q;
  logic             valid_q;

  // Borrow ripples LSB to MSB; bchain[i] is the borrow into bit i.
  assign bchain[0] = c;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_sub u_fs (
      .a_i    (a[gi]),
      .b_i    (b[gi]),
      .bin_i  (bchain[gi]),
      .diff_o (diff_d[gi]),
      .bout_o (bchain[gi+1])
    );
  end

  assign borr_d = bchain[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= '0;
      borr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= diff_d;
        borr_q <= borr_d;
      end
    end
  end

  assign diff      = diff_q;
  assign borr      = borr_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_full_half_sub.sv
// Directed checks of full_half_sub at WIDTH 1, 4 and 8 plus a randomised WIDTH-8 run
// against an arithmetic reference.

module tb_full_half_sub;
  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a1, b1, c1, v1, d1, br1, ov1;
  logic [3:0] a4, b4, d4;
  logic       c4, v4, br4, ov4;
  logic [7:0] a8, b8, d8;
  logic       c8, v8, br8, ov8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  full_half_sub #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(v1),
    .diff(d1), .borr(br1), .out_valid(ov1)
  );

  full_half_sub #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .in_valid(v4),
    .diff(d4), .borr(br4), .out_valid(ov4)
  );

  full_half_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .in_valid(v8),
    .diff(d8), .borr(br8), .out_valid(ov8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each row: a, b, c, expected diff, expected borrow
  logic [3:0] w4_a   [6] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd0,  4'd5};
  logic [3:0] w4_b   [6] = '{4'd5, 4'd4, 4'd0, 4'd0,  4'd15, 4'd5};
  logic       w4_c   [6] = '{1'b1, 1'b0, 1'b1, 1'b0,  1'b1,  1'b0};
  logic [3:0] w4_d   [6] = '{4'd13, 4'd5, 4'd15, 4'd15, 4'd0, 4'd0};
  logic       w4_br  [6] = '{1'b1, 1'b0, 1'b1, 1'b0,  1'b1,  1'b0};

  logic [7:0] tt_diff = 8'b1001_0110;
  logic [7:0] tt_borr = 8'b1000_1110;

  logic [8:0] exp8;
  logic       exp_ov8;

  initial begin
    {a1, b1, c1, v1} = '0;
    {a4, b4, c4, v4} = '0;
    {a8, b8, c8, v8} = '0;

    // Asynchronous reset, checked before the first clock edge at t=5
    #1;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; v1 = 1'b1;
    a4 = 4'd11; b4 = 4'd2; c4 = 1'b1; v4 = 1'b1;
    a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b0; v8 = 1'b1;
    #1;
    check("rst_w1_diff", 32'(d1), 0);
    check("rst_w1_borr", 32'(br1), 0);
    check("rst_w1_ov", 32'(ov1), 0);
    check("rst_w4_diff", 32'(d4), 0);
    check("rst_w8_ov", 32'(ov8), 0);

    tick();
    check("rst_hold_w1_ov", 32'(ov1), 0);
    check("rst_hold_w4_diff", 32'(d4), 0);

    v4 = 1'b0; v8 = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_w1_diff", 32'(d1), 1);
    check("first_w1_borr", 32'(br1), 0);
    check("first_w1_ov", 32'(ov1), 1);

    // Exhaustive 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      v1 = 1'b1;
      tick();
      check($sformatf("tt%0d_diff", i), 32'(d1), 32'(tt_diff[i]));
      check($sformatf("tt%0d_borr", i), 32'(br1), 32'(tt_borr[i]));
      check($sformatf("tt%0d_ov", i), 32'(ov1), 1);
    end

    // Hold when in_valid is low
    {a1, b1, c1} = 3'b010; v1 = 1'b1;
    tick();
    check("hold_cap_diff", 32'(d1), 1);
    check("hold_cap_borr", 32'(br1), 1);
    {a1, b1, c1} = 3'b100; v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d_diff", i), 32'(d1), 1);
      check($sformatf("hold%0d_borr", i), 32'(br1), 1);
      check($sformatf("hold%0d_ov", i), 32'(ov1), 0);
    end

    // WIDTH 4 directed vectors, back to back
    for (int i = 0; i < 6; i++) begin
      a4 = w4_a[i]; b4 = w4_b[i]; c4 = w4_c[i]; v4 = 1'b1;
      tick();
      check($sformatf("w4_%0d_diff", i), 32'(d4), 32'(w4_d[i]));
      check($sformatf("w4_%0d_borr", i), 32'(br4), 32'(w4_br[i]));
      check($sformatf("w4_%0d_ov", i), 32'(ov4), 1);
    end

    // Reset mid-stream on WIDTH 4
    for (int i = 0; i < 3; i++) begin
      a4 = 4'(i + 3); b4 = 4'(i); c4 = 1'b0; v4 = 1'b1;
      tick();
    end
    check("stream_pre_diff", 32'(d4), 3);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_diff", 32'(d4), 0);
    check("midrst_borr", 32'(br4), 0);
    check("midrst_ov", 32'(ov4), 0);
    a4 = 4'd7; b4 = 4'd2; c4 = 1'b1;
    tick();
    check("midrst_edge_ov", 32'(ov4), 0);
    check("midrst_edge_diff", 32'(d4), 0);
    #2;
    rst = 1'b0;
    a4 = 4'd12; b4 = 4'd3; c4 = 1'b0;
    tick();
    check("post_rst_diff", 32'(d4), 9);
    check("post_rst_borr", 32'(br4), 0);
    check("post_rst_ov", 32'(ov4), 1);
    v4 = 1'b0;

    // Random WIDTH 8 against arithmetic reference
    exp8 = 9'd0;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom_range(0, 1));
      v8 = 1'($urandom_range(0, 1));
      exp_ov8 = v8;
      if (v8) exp8 = {1'b0, a8} - {1'b0, b8} - {8'd0, c8};
      tick();
      check("rnd_w8_result", 32'({br8, d8}), 32'(exp8));
      check("rnd_w8_ov", 32'(ov8), 32'(exp_ov8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
